// File: rtl/fp_div_pkg.sv
// rtl/fp_div_pkg.sv - shared state encoding, flag indices and format constants for fp_div_iter
package fp_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIVIDE = 2'd1,
    ST_ROUND  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int FLAG_UNDERFLOW   = 0;
  localparam int FLAG_OVERFLOW    = 1;
  localparam int FLAG_DIV_BY_ZERO = 2;
  localparam int FLAG_INVALID     = 3;

  function automatic int exp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [63:0] qnan_bits(input int exp_w, input int man_w);
    logic [63:0] ones;
    ones = (64'd1 << exp_w) - 64'd1;
    return (ones << man_w) | (64'd1 << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_div_iter_if.sv
// rtl/fp_div_iter_if.sv - operand/result handshake bundle for fp_div_iter
interface fp_div_iter_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] c;
  logic [3:0]   flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, c, flags
  );
endinterface

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational operand classification and hidden-bit mantissa
module fp_classify
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] x_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic                 is_zero_o,
  output logic                 is_inf_o,
  output logic                 is_nan_o,
  output logic                 is_subnormal_o,
  output logic [MAN_W:0]       mant_o
);
  logic [MAN_W-1:0] frac;
  logic             exp_zero;
  logic             exp_ones;
  logic             frac_zero;

  assign sign_o    = x_i[EXP_W+MAN_W];
  assign exp_o     = x_i[EXP_W+MAN_W-1:MAN_W];
  assign frac      = x_i[MAN_W-1:0];
  assign exp_zero  = (exp_o == '0);
  assign exp_ones  = (exp_o == '1);
  assign frac_zero = (frac == '0);

  assign is_zero_o      = exp_zero & frac_zero;
  assign is_subnormal_o = exp_zero & ~frac_zero;
  assign is_inf_o       = exp_ones & frac_zero;
  assign is_nan_o       = exp_ones & ~frac_zero;
  assign mant_o         = {~exp_zero, frac};
endmodule

// File: rtl/fp_div_iter.sv
// rtl/fp_div_iter.sv - iterative radix-2 restoring floating-point divider with RNE rounding
module fp_div_iter
  import fp_div_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst,
  fp_div_iter_if.slave io
);
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int QW    = MAN_W + 3;
  localparam int EW2   = EXP_W + 2;
  localparam int CNT_W = $clog2(MAN_W + 4);

  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(MAN_W + 2);
  localparam logic [EXP_W-1:0]      EXP_ONES  = '1;
  localparam logic [W-1:0]          QNAN      = W'(qnan_bits(EXP_W, MAN_W));
  localparam logic signed [EW2-1:0] BIAS_E    = EW2'(exp_bias(EXP_W));
  localparam logic signed [EW2-1:0] ONE_E     = EW2'(1);
  localparam logic signed [EW2-1:0] ZERO_E    = EW2'(0);
  localparam logic signed [EW2-1:0] EXP_MAX_E = $signed({2'b00, EXP_ONES});

  logic             ca_sign, cb_sign;
  logic [EXP_W-1:0] ca_exp, cb_exp;
  logic             ca_zero, cb_zero, ca_inf, cb_inf;
  logic             ca_nan, cb_nan, ca_sub, cb_sub;
  logic [MAN_W:0]   ca_mant, cb_mant;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_a (
    .x_i(io.a), .sign_o(ca_sign), .exp_o(ca_exp), .is_zero_o(ca_zero),
    .is_inf_o(ca_inf), .is_nan_o(ca_nan), .is_subnormal_o(ca_sub), .mant_o(ca_mant)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_class_b (
    .x_i(io.b), .sign_o(cb_sign), .exp_o(cb_exp), .is_zero_o(cb_zero),
    .is_inf_o(cb_inf), .is_nan_o(cb_nan), .is_subnormal_o(cb_sub), .mant_o(cb_mant)
  );

  state_t                  state_q;
  logic                    in_ready_q, out_valid_q;
  logic [W-1:0]            c_q;
  logic [3:0]              flags_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [MAN_W+1:0]        rem_q;
  logic [MAN_W:0]          mb_q;
  logic [QW-1:0]           quo_q;
  logic signed [EW2-1:0]   exp_q;
  logic                    sign_q;
  logic                    spec_q;
  logic [W-1:0]            spec_c_q;
  logic [3:0]              spec_flags_q;

  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.c         = c_q;
  assign io.flags     = flags_q;

  // Special-operand outcome, decided at accept and carried through the fixed-latency pipeline.
  logic                  a_zero, b_zero, sign_d;
  logic                  spec_d;
  logic [W-1:0]          spec_c_d;
  logic [3:0]            spec_flags_d;
  logic signed [EW2-1:0] exp_d;

  always_comb begin
    a_zero       = ca_zero | ca_sub;
    b_zero       = cb_zero | cb_sub;
    sign_d       = ca_sign ^ cb_sign;
    spec_d       = 1'b1;
    spec_c_d     = '0;
    spec_flags_d = '0;
    exp_d        = $signed({2'b00, ca_exp}) - $signed({2'b00, cb_exp}) + BIAS_E;
    if (ca_nan | cb_nan | (a_zero & b_zero) | (ca_inf & cb_inf)) begin
      spec_c_d                   = QNAN;
      spec_flags_d[FLAG_INVALID] = 1'b1;
    end else if (ca_inf) begin
      spec_c_d = {sign_d, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      spec_c_d                       = {sign_d, EXP_ONES, {MAN_W{1'b0}}};
      spec_flags_d[FLAG_DIV_BY_ZERO] = 1'b1;
    end else if (cb_inf | a_zero) begin
      spec_c_d = {sign_d, {(W-1){1'b0}}};
    end else begin
      spec_d = 1'b0;
    end
  end

  logic [MAN_W+2:0] diff;
  logic             qbit;
  logic [MAN_W+1:0] rem_sel, rem_d;

  always_comb begin
    diff    = {1'b0, rem_q} - {2'b00, mb_q};
    qbit    = ~diff[MAN_W+2];
    rem_sel = qbit ? diff[MAN_W+1:0] : rem_q;
    rem_d   = rem_sel << 1;
  end

  // Normalise to [1,2), then round-to-nearest-even using guard, round and remainder sticky.
  logic                  msb, guard, rbit, sticky, rnd_up, carry;
  logic [MAN_W-1:0]      frac_pre, frac_d;
  logic signed [EW2-1:0] exp_fin;
  logic [W-1:0]          res_c_d;
  logic [3:0]            res_flags_d;

  always_comb begin
    msb         = quo_q[QW-1];
    frac_pre    = msb ? quo_q[QW-2:2] : quo_q[QW-3:1];
    guard       = msb ? quo_q[1] : quo_q[0];
    rbit        = msb & quo_q[0];
    sticky      = |rem_q;
    rnd_up      = guard & (rbit | sticky | frac_pre[0]);
    carry       = rnd_up & (&frac_pre);
    frac_d      = frac_pre + {{(MAN_W-1){1'b0}}, rnd_up};
    exp_fin     = exp_q - (msb ? ZERO_E : ONE_E) + (carry ? ONE_E : ZERO_E);
    res_c_d     = {sign_q, exp_fin[EXP_W-1:0], frac_d};
    res_flags_d = '0;
    if (spec_q) begin
      res_c_d     = spec_c_q;
      res_flags_d = spec_flags_q;
    end else if (exp_fin >= EXP_MAX_E) begin
      res_c_d                    = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      res_flags_d[FLAG_OVERFLOW] = 1'b1;
    end else if (exp_fin[EW2-1] || (exp_fin == ZERO_E)) begin
      res_c_d                     = {sign_q, {(W-1){1'b0}}};
      res_flags_d[FLAG_UNDERFLOW] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      c_q          <= '0;
      flags_q      <= '0;
      cnt_q        <= '0;
      rem_q        <= '0;
      mb_q         <= '0;
      quo_q        <= '0;
      exp_q        <= '0;
      sign_q       <= 1'b0;
      spec_q       <= 1'b0;
      spec_c_q     <= '0;
      spec_flags_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (io.in_valid && in_ready_q) begin
            rem_q        <= {1'b0, ca_mant};
            mb_q         <= cb_mant;
            quo_q        <= '0;
            exp_q        <= exp_d;
            sign_q       <= sign_d;
            spec_q       <= spec_d;
            spec_c_q     <= spec_c_d;
            spec_flags_q <= spec_flags_d;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            state_q      <= ST_DIVIDE;
          end
        end
        ST_DIVIDE: begin
          rem_q <= rem_d;
          quo_q <= {quo_q[QW-2:0], qbit};
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_ROUND;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_ROUND: begin
          c_q         <= res_c_d;
          flags_q     <= res_flags_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_div_iter.sv
// tb/tb_fp_div_iter.sv - randomized and directed self-checking bench for fp_div_iter
module tb_fp_div_iter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_div_iter_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk),
    .rst(rst),
    .io (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact long division on integers, then RNE on the true quotient.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] c, output logic [3:0] f);
    logic sa, sb, s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    int   ea, eb, e, top, sh;
    longint unsigned ma, mb, num, q, r, kept, low, half;
    sa = a[31]; sb = b[31]; s = sa ^ sb;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    a_nan = (ea == 255) && (a[22:0] != 0);
    b_nan = (eb == 255) && (b[22:0] != 0);
    a_inf = (ea == 255) && (a[22:0] == 0);
    b_inf = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    f = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      c = 32'h7FC00000; f = 4'b1000;
    end else if (a_inf) begin
      c = {s, 8'hFF, 23'h0};
    end else if (b_zero) begin
      c = {s, 8'hFF, 23'h0}; f = 4'b0100;
    end else if (b_inf || a_zero) begin
      c = {s, 31'h0};
    end else begin
      ma  = {40'd0, 1'b1, a[22:0]};
      mb  = {40'd0, 1'b1, b[22:0]};
      num = ma << 40;
      q   = num / mb;
      r   = num % mb;
      e   = ea - eb + 127;
      top = (q >= (64'd1 << 40)) ? 40 : 39;
      if (top == 39) e = e - 1;
      sh   = top - 23;
      kept = q >> sh;
      low  = q & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (low > half || (low == half && (r != 0 || (kept & 64'd1) != 0))) kept = kept + 1;
      if (kept == (64'd1 << 24)) begin
        kept = kept >> 1; e = e + 1;
      end
      if (e >= 255) begin
        c = {s, 8'hFF, 23'h0}; f = 4'b0010;
      end else if (e <= 0) begin
        c = {s, 31'h0}; f = 4'b0001;
      end else begin
        c = {s, 8'(e), kept[22:0]};
      end
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                        input string tag, output logic [31:0] got_c, output logic [3:0] got_f);
    logic [31:0] exp_c;
    logic [3:0]  exp_f;
    int          lat;
    model(a, b, exp_c, exp_f);
    @(negedge clk);
    bus.a = a; bus.b = b; bus.in_valid = 1'b1;
    check({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd28);
    check({tag, " c"}, 64'(bus.c), 64'(exp_c));
    check({tag, " flags"}, 64'(bus.flags), 64'(exp_f));
    check({tag, " busy"}, 64'(bus.in_ready), 64'd0);
    got_c = bus.c; got_f = bus.flags;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold c"}, 64'(bus.c), 64'(got_c));
      check({tag, " hold flags"}, 64'(bus.flags), 64'(got_f));
      check({tag, " hold valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, " hold busy"}, 64'(bus.in_ready), 64'd0);
    end
    @(negedge clk);
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.a = ~a;
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0;
    check({tag, " released"}, 64'(bus.out_valid), 64'd0);
    check({tag, " idle again"}, 64'(bus.in_ready), 64'd1);
  endtask

  function automatic logic [31:0] rand_operand();
    logic       s;
    logic [7:0] e;
    logic [22:0] m;
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom);
    case ($urandom_range(0, 11))
      0:       begin e = 8'd0; m = 23'd0; end
      1:       begin e = 8'hFF; m = 23'd0; end
      2:       begin e = 8'hFF; m[22] = 1'b1; end
      3:       e = 8'd0;
      4:       e = 8'($urandom_range(245, 254));
      5:       e = 8'($urandom_range(1, 10));
      6:       m = 23'h7FFFFF - 23'($urandom_range(0, 3));
      default: e = 8'($urandom_range(100, 154));
    endcase
    if ($urandom_range(0, 11) == 6) e = 8'($urandom_range(1, 254));
    return {s, e, m};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rc;
    logic [3:0]  rf;
    int          seen;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset in_ready", 64'(bus.in_ready), 64'd1);
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset c", 64'(bus.c), 64'd0);
    check("reset flags", 64'(bus.flags), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op(32'h40C00000, 32'h40000000, 0, "6/2", rc, rf);
    check("6/2 c spec", 64'(rc), 64'h40400000);
    check("6/2 flags spec", 64'(rf), 64'h0);
    run_op(32'h3F800000, 32'h40400000, 0, "1/3", rc, rf);
    check("1/3 c spec", 64'(rc), 64'h3EAAAAAB);
    run_op(32'h3F800000, 32'h00000000, 0, "1/0", rc, rf);
    check("1/0 c spec", 64'(rc), 64'h7F800000);
    check("1/0 flags spec", 64'(rf), 64'h4);
    run_op(32'h00000000, 32'h00000000, 0, "0/0", rc, rf);
    check("0/0 c spec", 64'(rc), 64'h7FC00000);
    check("0/0 flags spec", 64'(rf), 64'h8);
    run_op(32'h7F000000, 32'h3E800000, 0, "ovf", rc, rf);
    check("ovf c spec", 64'(rc), 64'h7F800000);
    check("ovf flags spec", 64'(rf), 64'h2);
    run_op(32'h00800000, 32'h7F000000, 0, "unf", rc, rf);
    check("unf c spec", 64'(rc), 64'h00000000);
    check("unf flags spec", 64'(rf), 64'h1);
    run_op(32'hC0C00000, 32'h40000000, 10, "stall", rc, rf);
    check("stall c spec", 64'(rc), 64'hC0400000);
    run_op(32'h7F800000, 32'hBF800000, 0, "inf/-1", rc, rf);
    run_op(32'h3F800000, 32'hFF800000, 0, "1/-inf", rc, rf);
    run_op(32'h00400000, 32'h3F800000, 0, "sub/1", rc, rf);

    // Abort mid-divide: result must never appear.
    @(negedge clk);
    bus.a = 32'h3F800000; bus.b = 32'h40400000; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort in_ready", 64'(bus.in_ready), 64'd1);
    check("abort out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    check("abort no result", 64'(seen), 64'd0);
    run_op(32'h40C00000, 32'h40000000, 0, "after abort", rc, rf);
    check("after abort c spec", 64'(rc), 64'h40400000);

    // Reset together with in_valid: operands must be dropped.
    @(negedge clk);
    rst = 1'b1; bus.in_valid = 1'b1; bus.a = 32'h40C00000; bus.b = 32'h40000000;
    @(posedge clk); #1;
    check("rst+valid in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk); rst = 1'b0; bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst+valid not captured", 64'(bus.in_ready), 64'd1);

    for (int n = 0; n < 40; n++) begin
      run_op(rand_operand(), rand_operand(), int'($urandom_range(0, 3)), $sformatf("rand%0d", n), rc, rf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
